// File: rtl/motor_sequencer.sv
// Line-following drive sequencer: filters the IR line sensor, picks a drive state and
// soft-ramps per-motor mode/duty so a motor never reverses while its duty is non-zero.
//
// state  | meaning
// IDLE   | not enabled, motors targeted to stop
// FWD    | line centred, both wheels at cruise
// LEFT   | line to the left, left wheel slowed
// RIGHT  | line to the right, right wheel slowed
// SEARCH | line lost, pivot toward the last turn direction
// HALT   | search timed out, motors stopped, lost asserted
module motor_sequencer #(
    parameter int RAMP_DIV     = 100000,
    parameter int RAMP_STEP    = 16,
    parameter int CRUISE_DUTY  = 700,
    parameter int TURN_DUTY    = 400,
    parameter int FILT_LEN     = 4,
    parameter int LOST_TIMEOUT = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] sensor,
    output logic [1:0] l_mode,
    output logic [1:0] r_mode,
    output logic [9:0] l_duty,
    output logic [9:0] r_duty,
    output logic [2:0] state,
    output logic       lost
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FWD    = 3'd1,
        ST_LEFT   = 3'd2,
        ST_RIGHT  = 3'd3,
        ST_SEARCH = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [1:0]  M_STOP   = 2'd0;
    localparam logic [1:0]  M_FWD    = 2'd1;
    localparam logic [1:0]  M_BACK   = 2'd2;
    localparam logic [9:0]  CRUISE10 = 10'((CRUISE_DUTY > 1023) ? 1023 : CRUISE_DUTY);
    localparam logic [9:0]  TURN10   = 10'((TURN_DUTY > 1023) ? 1023 : TURN_DUTY);
    localparam logic [10:0] STEP11   = 11'((RAMP_STEP > 1023) ? 1023 : RAMP_STEP);

    logic [31:0] div_cnt;
    logic        tick;
    logic [2:0]  samp_last;
    logic [31:0] match_cnt;
    logic [2:0]  filt;
    state_t      state_q, state_d;
    logic        last_left, last_left_d;
    logic [31:0] lost_cnt, lost_cnt_d;
    logic [1:0]  tl_mode, tr_mode;
    logic [9:0]  tl_duty, tr_duty;

    assign tick  = (div_cnt == 32'(RAMP_DIV - 1));
    assign state = state_q;
    assign lost  = (state_q == ST_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= 32'd0;
        end else if (tick) begin
            div_cnt <= 32'd0;
        end else begin
            div_cnt <= div_cnt + 32'd1;
        end
    end

    // The reset value of samp_last is never counted as a sample: match_cnt starts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_last <= 3'b000;
            match_cnt <= 32'd0;
            filt      <= 3'b000;
        end else if (tick) begin
            if (sensor == samp_last) begin
                if (match_cnt < 32'(FILT_LEN)) begin
                    match_cnt <= match_cnt + 32'd1;
                end
                if (match_cnt + 32'd1 >= 32'(FILT_LEN)) begin
                    filt <= sensor;
                end
            end else begin
                samp_last <= sensor;
                match_cnt <= 32'd1;
                if (32'(FILT_LEN) <= 32'd1) begin
                    filt <= sensor;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_left <= 1'b0;
            lost_cnt  <= 32'd0;
        end else begin
            state_q   <= state_d;
            last_left <= last_left_d;
            lost_cnt  <= lost_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_left_d = last_left;
        lost_cnt_d  = lost_cnt;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (tick) begin
            case (state_q)
                ST_IDLE: state_d = ST_FWD;
                ST_HALT: state_d = ST_HALT;
                ST_FWD, ST_LEFT, ST_RIGHT, ST_SEARCH: begin
                    if (state_q == ST_SEARCH && lost_cnt + 32'd1 >= 32'(LOST_TIMEOUT)) begin
                        state_d = ST_HALT;
                    end else begin
                        case (filt)
                            3'b010, 3'b111: state_d = ST_FWD;
                            3'b110, 3'b100: begin
                                state_d     = ST_LEFT;
                                last_left_d = 1'b1;
                            end
                            3'b011, 3'b001: begin
                                state_d     = ST_RIGHT;
                                last_left_d = 1'b0;
                            end
                            3'b000:  state_d = ST_SEARCH;
                            default: state_d = state_q;
                        endcase
                    end
                    if (state_q == ST_SEARCH) begin
                        lost_cnt_d = lost_cnt + 32'd1;
                    end else if (state_d == ST_SEARCH) begin
                        lost_cnt_d = 32'd0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tl_mode = M_STOP;
        tl_duty = 10'd0;
        tr_mode = M_STOP;
        tr_duty = 10'd0;
        case (state_q)
            ST_FWD: begin
                tl_mode = M_FWD;  tl_duty = CRUISE10;
                tr_mode = M_FWD;  tr_duty = CRUISE10;
            end
            ST_LEFT: begin
                tl_mode = M_FWD;  tl_duty = TURN10;
                tr_mode = M_FWD;  tr_duty = CRUISE10;
            end
            ST_RIGHT: begin
                tl_mode = M_FWD;  tl_duty = CRUISE10;
                tr_mode = M_FWD;  tr_duty = TURN10;
            end
            ST_SEARCH: begin
                tl_mode = last_left ? M_BACK : M_FWD;  tl_duty = TURN10;
                tr_mode = last_left ? M_FWD : M_BACK;  tr_duty = TURN10;
            end
            default: begin
                tl_mode = M_STOP;
                tr_mode = M_STOP;
            end
        endcase
    end

    // A mode change is only taken once duty has reached 0 under the old mode.
    function automatic logic [11:0] ramp_step(input logic [1:0] mode, input logic [9:0] duty,
                                              input logic [1:0] tmode, input logic [9:0] tduty);
        logic [10:0] d;
        logic [10:0] t;
        logic [10:0] up;
        logic [1:0]  m;
        d = {1'b0, duty};
        t = {1'b0, tduty};
        m = mode;
        up = d + STEP11;
        if (mode != tmode) begin
            if (d != 11'd0) begin
                d = (d > STEP11) ? d - STEP11 : 11'd0;
            end else begin
                m = tmode;
            end
        end else if (d < t) begin
            d = (up > t) ? t : up;
        end else if (d > t) begin
            d = (d - t > STEP11) ? d - STEP11 : t;
        end
        return {m, (d[10] ? 10'h3FF : d[9:0])};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            l_mode <= M_STOP;
            l_duty <= 10'd0;
            r_mode <= M_STOP;
            r_duty <= 10'd0;
        end else if (tick) begin
            {l_mode, l_duty} <= ramp_step(l_mode, l_duty, tl_mode, tl_duty);
            {r_mode, r_duty} <= ramp_step(r_mode, r_duty, tr_mode, tr_duty);
        end
    end

endmodule

// File: tb/tb_motor_sequencer.sv
// Bench for motor_sequencer: tick-level reference model of the sequencing rules,
// directed scenarios plus randomized sensor/enable traffic.
module tb_motor_sequencer;

    localparam int DIV = 4;
    localparam int STEP = 100;
    localparam int CRUISE = 700;
    localparam int TURN = 400;
    localparam int FL = 2;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] sensor = 3'b000;
    logic [1:0] l_mode, r_mode;
    logic [9:0] l_duty, r_duty;
    logic [2:0] state;
    logic       lost;

    int n_cmp = 0;
    int n_bad = 0;

    motor_sequencer #(
        .RAMP_DIV(DIV), .RAMP_STEP(STEP), .CRUISE_DUTY(CRUISE),
        .TURN_DUTY(TURN), .FILT_LEN(FL), .LOST_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .sensor(sensor),
        .l_mode(l_mode), .r_mode(r_mode), .l_duty(l_duty), .r_duty(r_duty),
        .state(state), .lost(lost)
    );

    always #5 clk = ~clk;

    // Reference model: states as plain ints 0..5, filter as a window of recent tick samples.
    int         m_div = 0, m_st = 0, m_sticks = 0;
    int         m_lm = 0, m_rm = 0, m_ld = 0, m_rd = 0;
    bit         m_ll = 0;
    logic [2:0] m_filt = 3'b000;
    logic [2:0] m_q[$];
    int         t_lm, t_ld, t_rm, t_rd, st0;
    logic [2:0] f0;
    bit         tk, same;

    function automatic void targets(input int st, input bit ll,
                                    output int lm, output int ld, output int rm, output int rd);
        lm = 0; ld = 0; rm = 0; rd = 0;
        case (st)
            1: begin lm = 1; ld = CRUISE; rm = 1; rd = CRUISE; end
            2: begin lm = 1; ld = TURN;   rm = 1; rd = CRUISE; end
            3: begin lm = 1; ld = CRUISE; rm = 1; rd = TURN;   end
            4: begin lm = ll ? 2 : 1; ld = TURN; rm = ll ? 1 : 2; rd = TURN; end
            default: ;
        endcase
    endfunction

    function automatic void slew(inout int m, inout int d, input int tm, input int td);
        if (m != tm) begin
            if (d > 0) d = (d > STEP) ? d - STEP : 0;
            else m = tm;
        end else if (d < td) begin
            d = (d + STEP > td) ? td : d + STEP;
        end else if (d > td) begin
            d = (d - STEP < td) ? td : d - STEP;
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_div = 0; m_st = 0; m_sticks = 0; m_ll = 0; m_filt = 3'b000;
            m_lm = 0; m_rm = 0; m_ld = 0; m_rd = 0;
            m_q.delete();
        end else begin
            tk = (m_div == DIV - 1);
            m_div = tk ? 0 : m_div + 1;
            st0 = m_st;
            f0 = m_filt;
            if (tk) begin
                targets(st0, m_ll, t_lm, t_ld, t_rm, t_rd);
                slew(m_lm, m_ld, t_lm, t_ld);
                slew(m_rm, m_rd, t_rm, t_rd);
                m_q.push_back(sensor);
                if (m_q.size() > FL) void'(m_q.pop_front());
                same = (m_q.size() == FL);
                foreach (m_q[i]) if (m_q[i] !== sensor) same = 0;
                if (same) m_filt = sensor;
            end
            if (!enable) begin
                m_st = 0;
            end else if (tk) begin
                if (st0 == 0) begin
                    m_st = 1;
                end else if (st0 >= 1 && st0 <= 4) begin
                    if (st0 == 4) m_sticks++;
                    if (st0 == 4 && m_sticks >= TO) m_st = 5;
                    else begin
                        case (f0)
                            3'b010, 3'b111: m_st = 1;
                            3'b110, 3'b100: begin m_st = 2; m_ll = 1; end
                            3'b011, 3'b001: begin m_st = 3; m_ll = 0; end
                            3'b000: m_st = 4;
                            default: ;
                        endcase
                    end
                    if (m_st == 4 && st0 != 4) m_sticks = 0;
                end
            end
        end
    end

    function automatic logic [27:0] dut_vec();
        return {state, lost, l_mode, r_mode, l_duty, r_duty};
    endfunction

    function automatic logic [27:0] mdl_vec();
        return {3'(m_st), (m_st == 5), 2'(m_lm), 2'(m_rm), 10'(m_ld), 10'(m_rd)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; sensor = 3'b000;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (dut_vec() !== 28'd0) begin
            n_bad++;
            $display("FAIL reset_hold: got %h want 0", dut_vec());
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({state, lost, l_mode, r_mode, l_duty, r_duty} !== 28'd0) begin
            n_bad++;
            $display("FAIL reset_release: got %h want 0", dut_vec());
        end
    endtask

    task automatic test_forward();
        sensor = 3'b010; enable = 1'b0;
        repeat (3 * DIV) begin
            @(negedge clk); n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++; $display("FAIL fwd_settle: got %h want %h", dut_vec(), mdl_vec());
            end
        end
        enable = 1'b1;
        repeat (12 * DIV) begin
            @(negedge clk); n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++; $display("FAIL fwd_model: got %h want %h", dut_vec(), mdl_vec());
            end
        end
        n_cmp++;
        if ({state, l_mode, r_mode, l_duty, r_duty} !== {3'd1, 2'd1, 2'd1, 10'd700, 10'd700}) begin
            n_bad++;
            $display("FAIL fwd_cruise: got st=%0d lm=%0d rm=%0d ld=%0d rd=%0d want 1/1/1/700/700",
                     state, l_mode, r_mode, l_duty, r_duty);
        end
    endtask

    task automatic test_left();
        sensor = 3'b110;
        repeat (8 * DIV) begin
            @(negedge clk); n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++; $display("FAIL left_model: got %h want %h", dut_vec(), mdl_vec());
            end
        end
        n_cmp++;
        if ({state, l_mode, r_mode, l_duty, r_duty} !== {3'd2, 2'd1, 2'd1, 10'd400, 10'd700}) begin
            n_bad++;
            $display("FAIL left_turn: got st=%0d lm=%0d rm=%0d ld=%0d rd=%0d want 2/1/1/400/700",
                     state, l_mode, r_mode, l_duty, r_duty);
        end
    endtask

    task automatic test_search_halt();
        bit saw_back = 0;
        sensor = 3'b000;
        repeat (30 * DIV) begin
            @(negedge clk); n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++; $display("FAIL search_model: got %h want %h", dut_vec(), mdl_vec());
            end
            if (state == 3'd4 && l_mode == 2'd2 && r_mode == 2'd1) saw_back = 1;
        end
        n_cmp++;
        if (saw_back !== 1'b1) begin
            n_bad++; $display("FAIL search_pivot: saw_back=%0d want 1", saw_back);
        end
        n_cmp++;
        if ({state, lost, l_mode, r_mode, l_duty, r_duty} !== {3'd5, 1'b1, 24'd0}) begin
            n_bad++;
            $display("FAIL halt: got st=%0d lost=%0d lm=%0d rm=%0d ld=%0d rd=%0d want 5/1/0/0/0/0",
                     state, lost, l_mode, r_mode, l_duty, r_duty);
        end
        enable = 1'b0;
        @(negedge clk); n_cmp++;
        if ({state, lost} !== {3'd0, 1'b0}) begin
            n_bad++; $display("FAIL halt_exit: got st=%0d lost=%0d want 0/0", state, lost);
        end
    endtask

    task automatic test_glitch();
        sensor = 3'b010; enable = 1'b1;
        repeat (16 * DIV) begin
            @(negedge clk); n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++; $display("FAIL glitch_setup: got %h want %h", dut_vec(), mdl_vec());
            end
        end
        sensor = 3'b100;
        repeat (DIV) @(negedge clk);
        sensor = 3'b010;
        repeat (8 * DIV) begin
            @(negedge clk); n_cmp++;
            if (state !== 3'd1) begin
                n_bad++; $display("FAIL glitch_state: got %0d want 1", state);
            end
        end
    endtask

    task automatic test_reset_midramp();
        int budget = 100;
        enable = 1'b0;
        while (l_duty !== 10'd400 && budget > 0) begin
            @(negedge clk); budget--; n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++; $display("FAIL midramp_model: got %h want %h", dut_vec(), mdl_vec());
            end
        end
        n_cmp++;
        if (budget == 0) begin
            n_bad++; $display("FAIL midramp_wait: l_duty=%0d want 400 within budget", l_duty);
        end
        rst = 1'b1;
        @(negedge clk); n_cmp++;
        if (dut_vec() !== 28'd0) begin
            n_bad++; $display("FAIL midramp_reset: got %h want 0", dut_vec());
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] plm, prm;
        logic [9:0] pld, prd;
        bit bad;
        plm = l_mode; prm = r_mode; pld = l_duty; prd = r_duty;
        for (int seg = 0; seg < 150; seg++) begin
            sensor = 3'($urandom_range(0, 7));
            enable = ($urandom_range(0, 15) != 0);
            repeat (DIV * $urandom_range(1, 6)) begin
                @(negedge clk); n_cmp++;
                if (dut_vec() !== mdl_vec()) begin
                    n_bad++; $display("FAIL rand_model: got %h want %h", dut_vec(), mdl_vec());
                end
                bad = (l_mode !== plm && pld != 10'd0) || (r_mode !== prm && prd != 10'd0) ||
                      l_mode == 2'd3 || r_mode == 2'd3;
                n_cmp++;
                if (bad) begin
                    n_bad++;
                    $display("FAIL rand_reversal: lm %0d->%0d at ld %0d, rm %0d->%0d at rd %0d",
                             plm, l_mode, pld, prm, r_mode, prd);
                end
                plm = l_mode; prm = r_mode; pld = l_duty; prd = r_duty;
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_left();
        test_search_halt();
        test_glitch();
        test_reset_midramp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
